// File: rtl/axonerve_multi_kernel_ctrl.sv
// ============================================================================
// Module   : axonerve_multi_kernel_ctrl
// Brief    : SDx ap_ctrl sequencer that kicks C_NUM_CH cores and collects
//            their busy falling edges, with a watchdog and a run-cycle counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axonerve_multi_kernel_ctrl #(
    parameter int C_NUM_CH         = 4,
    parameter int C_CHAIN_MODE     = 0,
    parameter int C_CYC_CNT_WIDTH  = 48,
    parameter int C_TIMEOUT_CYCLES = 0
) (
    input  logic                       ap_clk,
    input  logic                       areset,
    input  logic                       ap_start,
    input  logic                       ap_continue,
    output logic                       ap_idle,
    output logic                       ap_ready,
    output logic                       ap_done,
    input  logic [C_NUM_CH-1:0]        ch_enable,
    output logic [C_NUM_CH-1:0]        ch_kick,
    input  logic [C_NUM_CH-1:0]        ch_busy,
    output logic [C_NUM_CH-1:0]        ch_done_mask,
    output logic                       timeout,
    output logic [C_CYC_CNT_WIDTH-1:0] cycle_count
);

    localparam int TO_WIDTH = (C_TIMEOUT_CYCLES > 1) ? $clog2(C_TIMEOUT_CYCLES) : 1;
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(C_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_KICK = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_ap_start;
    logic [C_NUM_CH-1:0]   r_busy;
    logic [C_NUM_CH-1:0]   r_en;
    logic [TO_WIDTH-1:0]   r_run_cnt;

    logic                  w_start;
    logic [C_NUM_CH-1:0]   w_fall;
    logic                  w_complete;
    logic                  w_expire;

    assign w_start    = ap_start & ~r_ap_start & (r_state == S_IDLE);
    assign w_fall     = r_busy & ~ch_busy & r_en;
    assign w_complete = ((ch_done_mask | w_fall) == r_en);
    assign w_expire   = (C_TIMEOUT_CYCLES > 0) && (r_run_cnt == TO_LAST);

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ap_idle     = 1'b0;
        ap_ready    = 1'b0;
        ap_done     = 1'b0;
        ch_kick     = '0;
        case (r_state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (w_start) begin
                    w_state_nxt = (ch_enable == '0) ? S_DONE : S_KICK;
                end
            end
            S_KICK: begin
                ap_ready    = 1'b1;
                ch_kick     = r_en;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_complete || w_expire) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                ap_done = 1'b1;
                if ((C_CHAIN_MODE == 0) || ap_continue) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_ap_start   <= 1'b0;
            r_busy       <= '0;
            r_en         <= '0;
            r_run_cnt    <= '0;
            ch_done_mask <= '0;
            timeout      <= 1'b0;
            cycle_count  <= '0;
        end else begin
            r_ap_start <= ap_start;
            r_busy     <= ch_busy;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_en         <= ch_enable;
                        ch_done_mask <= '0;
                        timeout      <= 1'b0;
                        cycle_count  <= '0;
                    end
                end
                S_KICK: begin
                    // Falls seen here are leftovers from the previous run.
                    r_run_cnt <= '0;
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + C_CYC_CNT_WIDTH'(1);
                    end
                end
                S_RUN: begin
                    ch_done_mask <= ch_done_mask | w_fall;
                    r_run_cnt    <= r_run_cnt + TO_WIDTH'(1);
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + C_CYC_CNT_WIDTH'(1);
                    end
                    if (w_expire && !w_complete) begin
                        timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axonerve_multi_kernel_ctrl.sv
// ============================================================================
// Module   : tb_axonerve_multi_kernel_ctrl
// Brief    : Directed bench; instance a is handshake mode with a 20-cycle
//            watchdog, instance b is chain mode with a 4-bit cycle counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axonerve_multi_kernel_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_start = 1'b0, a_idle, a_ready, a_done, a_timeout;
    logic [3:0]  a_en = 4'h0, a_busy = 4'h0, a_kick, a_mask;
    logic [47:0] a_count;

    logic        b_start = 1'b0, b_cont = 1'b0, b_idle, b_ready, b_done, b_timeout;
    logic [3:0]  b_en = 4'h0, b_busy = 4'h0, b_kick, b_mask;
    logic [3:0]  b_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axonerve_multi_kernel_ctrl #(
        .C_NUM_CH(4), .C_CHAIN_MODE(0), .C_CYC_CNT_WIDTH(48), .C_TIMEOUT_CYCLES(20)
    ) dut_a (
        .ap_clk(clk), .areset(rst), .ap_start(a_start), .ap_continue(1'b0),
        .ap_idle(a_idle), .ap_ready(a_ready), .ap_done(a_done),
        .ch_enable(a_en), .ch_kick(a_kick), .ch_busy(a_busy),
        .ch_done_mask(a_mask), .timeout(a_timeout), .cycle_count(a_count)
    );

    axonerve_multi_kernel_ctrl #(
        .C_NUM_CH(4), .C_CHAIN_MODE(1), .C_CYC_CNT_WIDTH(4), .C_TIMEOUT_CYCLES(0)
    ) dut_b (
        .ap_clk(clk), .areset(rst), .ap_start(b_start), .ap_continue(b_cont),
        .ap_idle(b_idle), .ap_ready(b_ready), .ap_done(b_done),
        .ch_enable(b_en), .ch_kick(b_kick), .ch_busy(b_busy),
        .ch_done_mask(b_mask), .timeout(b_timeout), .cycle_count(b_count)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // All four channels busy 3..10, falling together at cycle 11.
    task automatic full_run();
        tick();
        a_en    = 4'hF;
        a_start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            a_start = 1'b0;
            a_busy  = (c >= 3 && c <= 10) ? 4'hF : 4'h0;
            check("full_done", a_done, c == 12);
            check("full_ready", a_ready, c == 1);
            check("full_kick", a_kick, (c == 1) ? 4'hF : 4'h0);
            if (c == 13) begin
                check("full_idle", a_idle, 1'b1);
                check("full_mask", a_mask, 4'hF);
                check("full_count", a_count, 11);
                check("full_timeout", a_timeout, 1'b0);
            end
        end
    endtask

    // Single channel 3; fall_at = 0 means it never falls.
    task automatic watchdog_run(input int fall_at, input logic exp_to);
        tick();
        a_en    = 4'h8;
        a_start = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            tick();
            a_start = 1'b0;
            a_busy  = (c >= 2 && (fall_at == 0 || c < fall_at)) ? 4'h8 : 4'h0;
            check("wd_done", a_done, c == 22);
            if (c == 22) check("wd_timeout", a_timeout, exp_to);
            if (c == 23) begin
                check("wd_idle", a_idle, 1'b1);
                check("wd_count", a_count, 21);
                check("wd_mask", a_mask, exp_to ? 4'h0 : 4'h8);
            end
        end
        a_busy = 4'h0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_idle", a_idle, 1'b1);
        check("rst_done", a_done, 1'b0);
        check("rst_ready", a_ready, 1'b0);
        check("rst_kick", a_kick, 4'h0);
        check("rst_mask", a_mask, 4'h0);
        check("rst_count", a_count, 0);
        check("rst_timeout", a_timeout, 1'b0);
        check("rst_b_idle", b_idle, 1'b1);
        rst = 1'b0;

        full_run();

        // Enable 0101: ch0 falls at 5, ch2 at 9, disabled ch1 toggles.
        tick();
        a_en    = 4'b0101;
        a_start = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            a_start = 1'b0;
            a_busy  = {1'b0, (c >= 2 && c <= 8), c[0], (c >= 2 && c <= 4)};
            check("sparse_kick1", a_kick[1], 1'b0);
            check("sparse_done", a_done, c == 10);
            if (c == 1) check("sparse_kick", a_kick, 4'b0101);
            if (c == 6) check("sparse_mask6", a_mask, 4'b0001);
            if (c == 11) check("sparse_mask", a_mask, 4'b0101);
        end
        a_busy = 4'h0;

        watchdog_run(0, 1'b1);
        // Fall seen on the 20th RUN cycle: completion beats the watchdog.
        watchdog_run(21, 1'b0);

        // Empty enable: straight to DONE, no kick, no ready, no rerun.
        tick();
        a_en    = 4'h0;
        a_start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check("empty_done", a_done, c == 1);
            check("empty_ready", a_ready, 1'b0);
            check("empty_kick", a_kick, 4'h0);
            check("empty_idle", a_idle, c != 1);
            if (c == 1) check("empty_count", a_count, 0);
        end
        a_start = 1'b0;

        // Chain mode with a 4-bit counter: ch0 falls at 17, continue at 25.
        tick();
        b_en    = 4'h1;
        b_start = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            tick();
            b_start = 1'b0;
            b_busy  = (c >= 2 && c <= 16) ? 4'h1 : 4'h0;
            b_cont  = (c >= 2 && c <= 10) || (c >= 25);
            check("chain_done", b_done, c >= 18 && c <= 25);
            if (c == 26) begin
                check("chain_idle", b_idle, 1'b1);
                check("chain_count_sat", b_count, 4'hF);
                check("chain_mask", b_mask, 4'h1);
            end
        end
        b_cont = 1'b0;

        // Reset mid-RUN with two channels still busy.
        tick();
        a_en    = 4'b0011;
        a_start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            a_start = 1'b0;
            a_busy  = (c >= 2) ? 4'b0011 : 4'h0;
            if (c == 4) check("mid_run_idle", a_idle, 1'b0);
        end
        rst = 1'b1;
        tick();
        check("arst_idle", a_idle, 1'b1);
        check("arst_done", a_done, 1'b0);
        check("arst_kick", a_kick, 4'h0);
        check("arst_mask", a_mask, 4'h0);
        check("arst_count", a_count, 0);
        rst    = 1'b0;
        a_busy = 4'h0;

        full_run();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axonerve_multi_kernel_ctrl.md
Name: axonerve_multi_kernel_ctrl

Overview:
Parametrised SDx kernel control sequencer for multi-core Axonerve kernels (wordcount, kvs). It converts the host ap_start/ap_idle/ap_ready/ap_done/ap_continue protocol into per-channel kick pulses for C_NUM_CH processing cores. It collects completion from each core's busy falling edge, and it provides an optional watchdog timeout and a run-cycle counter for host-side profiling.

Parameters:
C_NUM_CH, 4, number of core channels (1..32)
C_CHAIN_MODE, 0, 0 = ap_ctrl_hs (one-cycle ap_done); 1 = ap_ctrl_chain (ap_done held until ap_continue)
C_CYC_CNT_WIDTH, 48, width of cycle_count
C_TIMEOUT_CYCLES, 0, watchdog limit in RUN cycles; 0 disables the watchdog

Ports:
ap_clk  in  1  kernel clock
areset  in  1  synchronous, active-high reset; clock ap_clk
ap_start  in  1  host start, edge-detected
ap_continue  in  1  host acknowledge of done (used only when C_CHAIN_MODE=1)
ap_idle  out  1  high only in IDLE
ap_ready  out  1  one-cycle pulse when inputs are latched
ap_done  out  1  run complete
ch_enable  in  C_NUM_CH  channels to run, latched at start
ch_kick  out  C_NUM_CH  one-cycle kick per enabled channel
ch_busy  in  C_NUM_CH  per-core busy level
ch_done_mask  out  C_NUM_CH  sticky completed-channel bits
timeout  out  1  sticky watchdog flag for the last run
cycle_count  out  C_CYC_CNT_WIDTH  cycles spent in KICK+RUN for the last run

Behaviour:
- Reset values: ap_idle=1; all other outputs 0; state=IDLE; ap_start_r=0; busy_r=0; en_r=0.
- Reset mid-operation returns to IDLE in the next cycle and clears all outputs. No kick is issued.
- start_pulse = ap_start & ~ap_start_r. Because ap_start_r resets to 0, ap_start held high across reset release starts a run. start_pulse is ignored outside IDLE.
- busy_r registers ch_busy every cycle. fall = busy_r & ~ch_busy & en_r.
- The FSM has states IDLE, KICK, RUN, DONE. All outputs are registered from or decoded from the state.
- IDLE, on start_pulse:
  - latch en_r = ch_enable; clear ch_done_mask, timeout, cycle_count.
  - if ch_enable==0, go directly to DONE; otherwise go to KICK.
- KICK (one cycle):
  - ch_kick = en_r; ap_ready=1; cycle_count increments.
  - falls during KICK are ignored (stale edges from a previous run).
  - next state is RUN.
- RUN:
  - each cycle, ch_done_mask |= fall and cycle_count increments (saturates at all-ones, no wrap).
  - if (ch_done_mask | fall) == en_r, go to DONE; ap_done is high in the cycle after the last fall is seen.
  - if C_TIMEOUT_CYCLES>0 and the RUN cycle count reaches C_TIMEOUT_CYCLES, set timeout=1 and go to DONE.
  - if completion and timeout occur in the same cycle, completion wins and timeout stays 0.
  - multiple simultaneous falls are all recorded in the same cycle.
  - falls on disabled channels are ignored.
- DONE:
  - ap_done=1, ap_idle=0.
  - C_CHAIN_MODE=0: DONE lasts exactly one cycle, then IDLE.
  - C_CHAIN_MODE=1: stay in DONE until ap_continue=1 is sampled, then IDLE. ap_continue has no effect in other states.
- ap_idle rises the cycle after DONE exits. ch_done_mask, timeout and cycle_count hold their values until the next start_pulse.
- A start_pulse arriving in the same cycle as DONE exits is ignored; the host must re-raise ap_start.
- ch_busy never asserting on an enabled channel means no completion for that channel. Only the watchdog (if enabled) terminates the run.

Test Plan:
- C_NUM_CH=4, ch_enable=4'b1111, ap_start rises at cycle 0 -> ch_kick=4'b1111 and ap_ready at cycle 1. Busy on all channels cycles 3..10, all fall at cycle 11 -> ap_done pulse at cycle 12 only, ap_idle=1 at cycle 13, ch_done_mask=4'hF, cycle_count=11.
- ch_enable=4'b0101, ch0 falls at cycle 5, ch2 falls at cycle 9, ch1 toggles (disabled) -> ch_done_mask=4'b0001 after cycle 5, ap_done at cycle 10, ch_kick[1] never high.
- C_TIMEOUT_CYCLES=20, ch3 enabled and busy never falls -> timeout=1, ap_done after 20 RUN cycles. Next start clears timeout.
- C_CHAIN_MODE=1, run completes, ap_continue held low for 7 cycles then high -> ap_done high for 8 cycles, IDLE on the following cycle.
- ch_enable=0 with ap_start rising -> ap_done one cycle later, no kick issued, ap_ready never asserted. ap_start held high afterwards -> no second run.
- areset asserted mid-RUN with 2 channels pending -> next cycle ap_idle=1, ap_done=0, ch_kick=0. A new start runs normally.
